// File: rtl/wifi_tx_pkg.sv
// Shared definitions for the WiFi transmit convolutional encoder.
// Holds the default K=7 generator polynomials, the Rate input encodings,
// the encoder FSM state encoding, and the tap/parity helper used to form
// one coded bit.
package wifi_tx_pkg;

  localparam logic [6:0] G0_DEFAULT = 7'o133;
  localparam logic [6:0] G1_DEFAULT = 7'o171;

  typedef enum logic [1:0] {
    RATE_1_2  = 2'b00,
    RATE_2_3  = 2'b01,
    RATE_3_4  = 2'b10,
    RATE_RSVD = 2'b11  // behaves as rate 1/2
  } rate_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ENCODE,
    ST_DRAIN
  } state_e;

  // Generator bit 6 taps the current input; bit 5 taps s[0] (newest) down
  // to bit 0 tapping s[5] (oldest), so the register is reversed into
  // delay order before masking.
  function automatic logic coded_bit(input logic [6:0] gen,
                                     input logic       din,
                                     input logic [5:0] s);
    logic [5:0] s_delay;
    s_delay = {s[0], s[1], s[2], s[3], s[4], s[5]};
    return ^(gen & {din, s_delay});
  endfunction

endpackage

// File: rtl/puncture_unit.sv
// Puncturing control for the convolutional encoder.
// Tracks the puncture phase (advanced once per accepted input bit) and
// reports which of the two coded bits (A, B) survive for the current bit.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - restart the phase at 0 (frame start)
//   advance     - an input bit was accepted this cycle
//   rate        - rate latched for the current frame
//   keep_a      - coded bit A survives for the current phase
//   keep_b      - coded bit B survives for the current phase
module puncture_unit
  import wifi_tx_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  logic  advance,
  input  rate_e rate,
  output logic  keep_a,
  output logic  keep_b
);

  logic [1:0] phase;
  logic [1:0] phase_max;

  always_comb begin
    phase_max = '0;
    case (rate)
      RATE_2_3: phase_max = 2'd1;
      RATE_3_4: phase_max = 2'd2;
      default:  phase_max = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (advance) begin
      phase <= (phase >= phase_max) ? 2'd0 : phase + 2'd1;
    end
  end

  // 2/3: phase 1 drops B.  3/4: phase 1 drops B, phase 2 drops A.
  always_comb begin
    keep_a = 1'b1;
    keep_b = 1'b1;
    case (rate)
      RATE_2_3: begin
        if (phase == 2'd1) keep_b = 1'b0;
      end
      RATE_3_4: begin
        if (phase == 2'd1)      keep_b = 1'b0;
        else if (phase == 2'd2) keep_a = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/convolutional_encoder.sv
// K=7 convolutional encoder with 1/2, 2/3 and 3/4 puncturing.
// Each accepted input bit produces coded bits A then B; punctured bits are
// dropped and the survivors are queued in a 2-entry pending buffer that
// drains through a valid/ready output.
// Ports:
//   Clock, Reset        - clock, asynchronous active-low reset
//   Start, Rate         - frame start pulse (IDLE only) and latched rate
//   InValid/Input/InLast/InReady     - input bit stream handshake
//   OutValid/Output/OutLast/OutReady - coded bit stream handshake
// Parameters:
//   G0, G1 - generator tap masks for coded bits A and B
module convolutional_encoder
  import wifi_tx_pkg::*;
#(
  parameter logic [6:0] G0 = G0_DEFAULT,
  parameter logic [6:0] G1 = G1_DEFAULT
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [1:0] Rate,
  input  logic       InValid,
  input  logic       Input,
  input  logic       InLast,
  output logic       InReady,
  output logic       OutValid,
  output logic       Output,
  output logic       OutLast,
  input  logic       OutReady
);

  state_e     state_q, state_d;
  rate_e      rate_q;
  logic [5:0] s_q;
  logic [1:0] pend_bit;   // entry 0 is the head
  logic [1:0] pend_last;
  logic [1:0] pend_cnt;

  logic in_ready;
  logic in_xfer;
  logic out_xfer;
  logic start_accept;
  logic frame_end;
  logic code_a, code_b;
  logic keep_a, keep_b;

  assign OutValid = (pend_cnt != 2'd0);
  assign Output   = pend_bit[0];
  assign OutLast  = pend_last[0];
  assign InReady  = in_ready;

  assign out_xfer = OutValid && OutReady;
  assign code_a   = coded_bit(G0, Input, s_q);
  assign code_b   = coded_bit(G1, Input, s_q);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    start_accept = 1'b0;
    frame_end    = 1'b0;
    in_xfer      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          start_accept = 1'b1;
          state_d      = ST_ENCODE;
        end
      end
      ST_ENCODE: begin
        // Room for up to two new bits once the buffer is empty, or is
        // emptying this cycle.
        in_ready = (pend_cnt == 2'd0) || ((pend_cnt == 2'd1) && OutReady);
        in_xfer  = InValid && in_ready;
        if (in_xfer && InLast) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_xfer && OutLast) begin
          frame_end = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rate_q <= RATE_1_2;
    end else if (start_accept) begin
      rate_q <= rate_e'(Rate);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      s_q <= '0;
    end else if (start_accept || frame_end) begin
      s_q <= '0;
    end else if (in_xfer) begin
      s_q <= {s_q[4:0], Input};
    end
  end

  puncture_unit u_puncture (
    .clk     (Clock),
    .rst_n   (Reset),
    .clear   (start_accept),
    .advance (in_xfer),
    .rate    (rate_q),
    .keep_a  (keep_a),
    .keep_b  (keep_b)
  );

  // A load only happens when the buffer is empty after this cycle's pop,
  // so a load simply overwrites both entries; OutLast rides on whichever
  // surviving bit comes last.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pend_bit  <= '0;
      pend_last <= '0;
      pend_cnt  <= '0;
    end else if (in_xfer) begin
      if (keep_a && keep_b) begin
        pend_bit  <= {code_b, code_a};
        pend_last <= {InLast, 1'b0};
        pend_cnt  <= 2'd2;
      end else begin
        pend_bit  <= {1'b0, keep_a ? code_a : code_b};
        pend_last <= {1'b0, InLast};
        pend_cnt  <= 2'd1;
      end
    end else if (out_xfer) begin
      pend_bit  <= {1'b0, pend_bit[1]};
      pend_last <= {1'b0, pend_last[1]};
      pend_cnt  <= pend_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_convolutional_encoder.sv
// Self-checking bench for convolutional_encoder: directed frames with
// known coded sequences plus randomized frames compared against a
// tap-by-delay reference model of the code and puncture pattern.
module tb_convolutional_encoder;

  logic       Clock    = 1'b0;
  logic       Reset    = 1'b0;
  logic       Start    = 1'b0;
  logic [1:0] Rate     = 2'b00;
  logic       InValid  = 1'b0;
  logic       Input    = 1'b0;
  logic       InLast   = 1'b0;
  logic       OutReady = 1'b0;
  logic       InReady, OutValid, Output, OutLast;

  localparam logic [6:0] GA = 7'o133;
  localparam logic [6:0] GB = 7'o171;

  int passes = 0;
  int fails  = 0;
  int checks = 0;

  bit in_bits[$];
  bit exp_bits[$];
  bit exp_last[$];
  bit got_bits[$];
  bit got_last[$];

  convolutional_encoder #(.G0(GA), .G1(GB)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Rate     (Rate),
    .InValid  (InValid),
    .Input    (Input),
    .InLast   (InLast),
    .InReady  (InReady),
    .OutValid (OutValid),
    .Output   (Output),
    .OutLast  (OutLast),
    .OutReady (OutReady)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input logic [31:0] pat, input int n);
    in_bits.delete();
    for (int i = n - 1; i >= 0; i--) in_bits.push_back(pat[i]);
  endtask

  task automatic set_expected(input logic [31:0] pat, input int n);
    exp_bits.delete();
    exp_last.delete();
    for (int i = n - 1; i >= 0; i--) begin
      exp_bits.push_back(pat[i]);
      exp_last.push_back(i == 0);
    end
  endtask

  task automatic random_inputs(input int n);
    in_bits.delete();
    for (int i = 0; i < n; i++) in_bits.push_back(bit'($urandom_range(0, 1)));
  endtask

  // Reference: each coded bit is the parity of the input history taps
  // (delay d tapped by generator bit 6-d), then the puncture table drops
  // bits by position within the rate period.
  task automatic build_expected(input logic [1:0] rate);
    int period;
    exp_bits.delete();
    exp_last.delete();
    period = (rate == 2'b01) ? 2 : (rate == 2'b10) ? 3 : 1;
    for (int k = 0; k < in_bits.size(); k++) begin
      bit a, b, ka, kb, last;
      int ph;
      a = 1'b0;
      b = 1'b0;
      for (int d = 0; d <= 6; d++) begin
        if (k - d >= 0) begin
          if (GA[6-d]) a ^= in_bits[k-d];
          if (GB[6-d]) b ^= in_bits[k-d];
        end
      end
      ph   = k % period;
      ka   = !(period == 3 && ph == 2);
      kb   = (ph == 0) || (period == 3 && ph == 2);
      last = (k == in_bits.size() - 1);
      if (ka) begin
        exp_bits.push_back(a);
        exp_last.push_back(last && !kb);
      end
      if (kb) begin
        exp_bits.push_back(b);
        exp_last.push_back(last);
      end
    end
  endtask

  // mode 0: ready/valid held high; 1: random ready/valid;
  // 2: five-cycle OutReady stall after the third output; 3: second Start mid-frame
  task automatic run_frame(input logic [1:0] rate, input int mode, input string tag);
    int   idx, cyc, nout, stall_left;
    bit   done, stalled;
    logic hold_bit, hold_last;
    idx = 0; cyc = 0; nout = 0; stall_left = 0;
    done = 1'b0; stalled = 1'b0;
    hold_bit = 1'b0; hold_last = 1'b0;
    got_bits.delete();
    got_last.delete();
    @(negedge Clock);
    Start = 1'b1; Rate = rate; InValid = 1'b1; Input = 1'b1; InLast = 1'b0; OutReady = 1'b1;
    #1 check({tag, " idle_inready"}, InReady, 0);
    @(negedge Clock);
    Start = 1'b0;
    Rate  = 2'($urandom_range(0, 3));
    while (!done && cyc < 2000) begin
      Start = (mode == 3 && cyc == 2);
      if (mode == 3 && cyc == 2) Rate = 2'b01;
      if (mode == 2 && nout == 3 && !stalled) begin
        stall_left = 5;
        stalled    = 1'b1;
      end
      OutReady = (stall_left > 0) ? 1'b0 :
                 (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (idx < in_bits.size()) begin
        InValid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        Input   = in_bits[idx];
        InLast  = (idx == in_bits.size() - 1);
      end else begin
        InValid = 1'($urandom_range(0, 1));
        Input   = 1'($urandom_range(0, 1));
        InLast  = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        if (stall_left == 5) begin
          hold_bit  = Output;
          hold_last = OutLast;
        end else begin
          check($sformatf("%s stall_data c%0d", tag, stall_left), Output, hold_bit);
          check($sformatf("%s stall_last c%0d", tag, stall_left), OutLast, hold_last);
        end
        check($sformatf("%s stall_valid c%0d", tag, stall_left), OutValid, 1);
        check($sformatf("%s stall_inready c%0d", tag, stall_left), InReady, 0);
        stall_left--;
      end
      if (OutValid && OutReady) begin
        got_bits.push_back(Output);
        got_last.push_back(OutLast);
        nout++;
        if (OutLast) done = 1'b1;
      end
      if (InValid && InReady) idx++;
      @(negedge Clock);
      cyc++;
    end
    Start = 1'b0;
    check({tag, " frame_done"}, done, 1);
    check({tag, " inputs_taken"}, idx, in_bits.size());
    check({tag, " out_count"}, got_bits.size(), exp_bits.size());
    for (int i = 0; i < got_bits.size() && i < exp_bits.size(); i++) begin
      check($sformatf("%s bit%0d", tag, i), got_bits[i], exp_bits[i]);
      check($sformatf("%s last%0d", tag, i), got_last[i], exp_last[i]);
    end
    InValid = 1'b1;
    #1;
    check({tag, " idle_outvalid"}, OutValid, 0);
    check({tag, " idle_inready_after"}, InReady, 0);
    InValid = 1'b0;
  endtask

  initial begin
    // reset state
    #12;
    check("reset inready", InReady, 0);
    check("reset outvalid", OutValid, 0);
    check("reset output", Output, 0);
    check("reset outlast", OutLast, 0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;

    // impulse response at rate 1/2
    set_inputs(32'b1000000, 7);
    set_expected(32'b11011111001011, 14);
    run_frame(2'b00, 0, "r12_impulse");

    // rate 3/4 impulse
    set_inputs(32'b100000, 6);
    set_expected(32'b11011100, 8);
    run_frame(2'b10, 0, "r34_impulse");

    // rate 2/3 impulse
    set_inputs(32'b1000, 4);
    set_expected(32'b110111, 6);
    run_frame(2'b01, 0, "r23_impulse");

    // output stall mid-frame
    random_inputs(12);
    build_expected(2'b00);
    run_frame(2'b00, 2, "stall");

    // reset mid-frame, then a fresh short frame
    random_inputs(20);
    @(negedge Clock);
    Start = 1'b1; Rate = 2'b00; OutReady = 1'b1; InValid = 1'b0;
    @(negedge Clock);
    Start = 1'b0; InValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Input = in_bits[i];
      @(negedge Clock);
    end
    #2 Reset = 1'b0;
    #1;
    check("midreset inready", InReady, 0);
    check("midreset outvalid", OutValid, 0);
    check("midreset output", Output, 0);
    check("midreset outlast", OutLast, 0);
    InValid = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    #1 check("post_reset outvalid", OutValid, 0);
    set_inputs(32'b10, 2);
    set_expected(32'b1101, 4);
    run_frame(2'b00, 0, "after_reset");

    // reserved rate plus an ignored Start during ENCODE
    random_inputs(8);
    build_expected(2'b11);
    run_frame(2'b11, 3, "rate11_restart");

    // randomized frames, all rates, random handshakes
    for (int f = 0; f < 8; f++) begin
      logic [1:0] r;
      r = 2'($urandom_range(0, 3));
      random_inputs(int'($urandom_range(1, 30)));
      build_expected(r);
      run_frame(r, 1, $sformatf("rand%0d_rate%0d", f, r));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
